// File: rtl/sm_dmem_responder.sv
// Data-memory target for the core's M-stage port: on-chip RAM, GPIO/ID MMIO bank, optional
// compare timer (built when SM_DMEM_TIMER_EN is defined), and a sticky unmapped-write flag.
module sm_dmem_responder #(
  parameter int AW     = 6,
  parameter int GPIO_W = 8,
  parameter int PRESC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dmAddr,
  input  logic              dmWe,
  input  logic [31:0]       dmWData,
  output logic [31:0]       dmRData,
  input  logic [GPIO_W-1:0] gpioIn,
  output logic [GPIO_W-1:0] gpioOut,
  output logic              irq,
  output logic              busErr
);

  localparam logic [31:0] ID_VAL = 32'h534D_0001;

  logic          sel_ram;
  logic          sel_io;
  logic          io_we;
  logic [2:0]    reg_idx;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  assign sel_ram          = (dmAddr[31:16] == 16'h0000);
  assign sel_io           = (dmAddr[31:16] == 16'h8000);
  assign io_we            = dmWe && sel_io;
  assign reg_idx          = dmAddr[4:2];
  assign ram_idx          = dmAddr[AW+1:2];
  assign unused_addr_bits = ^dmAddr[15:0];

  // RAM is deliberately not reset; a write coinciding with reset is dropped.
  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (!rst && dmWe && sel_ram) mem_q[ram_idx] <= dmWData;
  end

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic              bus_err_q, bus_err_d;

  always_comb begin
    gpio_out_d = gpio_out_q;
    bus_err_d  = bus_err_q;
    if (io_we && reg_idx == 3'd0) gpio_out_d = dmWData[GPIO_W-1:0];
    if (dmWe && !sel_ram && !sel_io) bus_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpioIn;
      sync2_q    <= sync1_q;
      bus_err_q  <= bus_err_d;
    end
  end

  logic [31:0] tmr_cnt_rd;
  logic [31:0] tmr_cmp_rd;
  logic [1:0]  tmr_stat_rd;

`ifdef SM_DMEM_TIMER_EN
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   cmp_q, cmp_d;
  logic          match_q, match_d;
  logic          ie_q, ie_d;
  logic          tick, wr_cnt, wr_cmp, wr_stat;

  assign tick    = (presc_q == PW'(PRESC - 1));
  assign wr_cnt  = io_we && reg_idx == 3'd2;
  assign wr_cmp  = io_we && reg_idx == 3'd3;
  assign wr_stat = io_we && reg_idx == 3'd4;

  // A CPU write to CNT pre-empts the tick; a match set beats a same-cycle W1C.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    ie_d    = ie_q;
    if (wr_cmp) cmp_d = dmWData;
    if (wr_stat) begin
      ie_d = dmWData[1];
      if (dmWData[0]) match_d = 1'b0;
    end
    if (wr_cnt) begin
      cnt_d = dmWData;
    end else if (tick) begin
      if (cnt_q == cmp_q) begin
        cnt_d   = '0;
        match_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ie_q    <= ie_d;
    end
  end

  assign tmr_cnt_rd  = cnt_q;
  assign tmr_cmp_rd  = cmp_q;
  assign tmr_stat_rd = {ie_q, match_q};
  assign irq         = match_q & ie_q;
`else
  assign tmr_cnt_rd  = '0;
  assign tmr_cmp_rd  = '0;
  assign tmr_stat_rd = '0;
  assign irq         = 1'b0;
`endif

  always_comb begin
    dmRData = '0;
    if (sel_ram) begin
      dmRData = mem_q[ram_idx];
    end else if (sel_io) begin
      case (reg_idx)
        3'd0:    dmRData = 32'(gpio_out_q);
        3'd1:    dmRData = 32'(sync2_q);
        3'd2:    dmRData = tmr_cnt_rd;
        3'd3:    dmRData = tmr_cmp_rd;
        3'd4:    dmRData = {30'd0, tmr_stat_rd};
        3'd5:    dmRData = ID_VAL;
        default: dmRData = '0;
      endcase
    end
  end

  assign gpioOut = gpio_out_q;
  assign busErr  = bus_err_q;

endmodule

// File: tb/tb_sm_dmem_responder.sv
// Bench for sm_dmem_responder: directed vector table, hand-written timer/reset sequences,
// and randomized traffic checked against a behavioural model of the memory map.
module tb_sm_dmem_responder;

  localparam int AW     = 6;
  localparam int GPIO_W = 8;
  localparam int PRESC  = 4;
`ifdef SM_DMEM_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif
  localparam logic [31:0] ID_VAL = 32'h534D_0001;
  localparam logic [31:0] A_GOUT = 32'h8000_0000;
  localparam logic [31:0] A_GIN  = 32'h8000_0004;
  localparam logic [31:0] A_CNT  = 32'h8000_0008;
  localparam logic [31:0] A_CMP  = 32'h8000_000C;
  localparam logic [31:0] A_STAT = 32'h8000_0010;
  localparam logic [31:0] A_ID   = 32'h8000_0014;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       dmAddr = '0;
  logic              dmWe = 1'b0;
  logic [31:0]       dmWData = '0;
  logic [31:0]       dmRData;
  logic [GPIO_W-1:0] gpioIn = '0;
  logic [GPIO_W-1:0] gpioOut;
  logic              irq;
  logic              busErr;

  int n_cmp = 0;
  int n_bad = 0;

  sm_dmem_responder #(.AW(AW), .GPIO_W(GPIO_W), .PRESC(PRESC)) dut (
    .clk(clk), .rst(rst), .dmAddr(dmAddr), .dmWe(dmWe), .dmWData(dmWData),
    .dmRData(dmRData), .gpioIn(gpioIn), .gpioOut(gpioOut), .irq(irq), .busErr(busErr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural model of the memory map
  logic [31:0]       m_ram [2**AW];
  logic [GPIO_W-1:0] m_gout, m_pin1, m_pin2;
  logic [31:0]       m_cnt, m_cmp;
  logic              m_match, m_ie, m_berr;
  int                since_rst;

  task automatic model_reset();
    m_gout = '0; m_pin1 = '0; m_pin2 = '0;
    m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_match = 1'b0; m_ie = 1'b0;
    m_berr = 1'b0; since_rst = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return m_ram[a[AW+1:2]];
    if (a[31:16] != 16'h8000) return 32'd0;
    case (a[4:2])
      3'd0: return 32'(m_gout);
      3'd1: return 32'(m_pin2);
      3'd2: return TIMER_ON ? m_cnt : 32'd0;
      3'd3: return TIMER_ON ? m_cmp : 32'd0;
      3'd4: return TIMER_ON ? {30'd0, m_ie, m_match} : 32'd0;
      3'd5: return ID_VAL;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic       io, tick, wr_cnt, set_m;
    logic [2:0] idx;
    logic [31:0] n_cnt;
    io    = (dmAddr[31:16] == 16'h8000);
    idx   = dmAddr[4:2];
    tick  = (since_rst % PRESC) == PRESC - 1;
    if (dmWe && dmAddr[31:16] == 16'h0000) m_ram[dmAddr[AW+1:2]] = dmWData;
    if (dmWe && !io && dmAddr[31:16] != 16'h0000) m_berr = 1'b1;
    if (dmWe && io && idx == 3'd0) m_gout = dmWData[GPIO_W-1:0];
    if (TIMER_ON) begin
      wr_cnt = dmWe && io && idx == 3'd2;
      set_m  = tick && !wr_cnt && (m_cnt == m_cmp);
      if (wr_cnt) n_cnt = dmWData;
      else if (tick) n_cnt = (m_cnt == m_cmp) ? 32'd0 : m_cnt + 32'd1;
      else n_cnt = m_cnt;
      if (dmWe && io && idx == 3'd3) m_cmp = dmWData;
      if (dmWe && io && idx == 3'd4) begin
        m_ie = dmWData[1];
        if (dmWData[0]) m_match = 1'b0;
      end
      if (set_m) m_match = 1'b1;
      m_cnt = n_cnt;
    end
    m_pin2 = m_pin1;
    m_pin1 = gpioIn;
    since_rst++;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    check("model_rdata", dmRData, m_read(dmAddr));
    check("model_gpioOut", 32'(gpioOut), 32'(m_gout));
    check("model_busErr", 32'(busErr), 32'(m_berr));
    check("model_irq", 32'(irq), 32'(TIMER_ON && m_match && m_ie));
  endtask

  // driver tasks: called #1 after a rising edge
  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd);
    dmAddr = a; dmWe = we; dmWData = wd;
    #3;
    chk_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic [31:0] a, input logic we, input logic [31:0] wd);
    drive(a, we, wd);
    edge_step();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; dmWe = 1'b0;
    model_reset();
    #1;
    check("rst_gpioOut", 32'(gpioOut), 32'd0);
    check("rst_busErr", 32'(busErr), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [7:0]  gin;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gout;
    logic        exp_berr;
  } vec_t;

  vec_t tbl[20];
  int   found;

  initial begin
    tbl[0]  = '{32'h0000_0004, 1'b1, 32'hCAFE_0001, 8'h00, 32'h0000_0000, 8'h00, 1'b0};
    tbl[1]  = '{32'h0000_0004, 1'b0, 32'h0,         8'h00, 32'hCAFE_0001, 8'h00, 1'b0};
    tbl[2]  = '{32'h0000_0104, 1'b0, 32'h0,         8'h00, 32'hCAFE_0001, 8'h00, 1'b0};
    tbl[3]  = '{32'h0000_0004, 1'b1, 32'h0000_1234, 8'h00, 32'hCAFE_0001, 8'h00, 1'b0};
    tbl[4]  = '{32'h0000_0004, 1'b0, 32'h0,         8'h00, 32'h0000_1234, 8'h00, 1'b0};
    tbl[5]  = '{A_GOUT,        1'b1, 32'hFFFF_FFA5, 8'h00, 32'h0000_0000, 8'h00, 1'b0};
    tbl[6]  = '{A_GOUT,        1'b0, 32'h0,         8'h00, 32'h0000_00A5, 8'hA5, 1'b0};
    tbl[7]  = '{A_ID,          1'b0, 32'h0,         8'h00, ID_VAL,        8'hA5, 1'b0};
    tbl[8]  = '{A_ID,          1'b1, 32'h0,         8'h00, ID_VAL,        8'hA5, 1'b0};
    tbl[9]  = '{A_ID,          1'b0, 32'h0,         8'h00, ID_VAL,        8'hA5, 1'b0};
    tbl[10] = '{32'h8000_0FF4, 1'b0, 32'h0,         8'h00, ID_VAL,        8'hA5, 1'b0};
    tbl[11] = '{32'h8000_0018, 1'b1, 32'h0000_DEAD, 8'h00, 32'h0000_0000, 8'hA5, 1'b0};
    tbl[12] = '{32'h8000_0018, 1'b0, 32'h0,         8'h00, 32'h0000_0000, 8'hA5, 1'b0};
    tbl[13] = '{32'h4000_0000, 1'b1, 32'h0000_1234, 8'h00, 32'h0000_0000, 8'hA5, 1'b0};
    tbl[14] = '{32'h4000_0000, 1'b0, 32'h0,         8'h00, 32'h0000_0000, 8'hA5, 1'b1};
    tbl[15] = '{32'h0000_0004, 1'b0, 32'h0,         8'h00, 32'h0000_1234, 8'hA5, 1'b1};
    tbl[16] = '{32'h0001_0004, 1'b0, 32'h0,         8'h00, 32'h0000_0000, 8'hA5, 1'b1};
    tbl[17] = '{A_GIN,         1'b0, 32'h0,         8'h3C, 32'h0000_0000, 8'hA5, 1'b1};
    tbl[18] = '{A_GIN,         1'b0, 32'h0,         8'h3C, 32'h0000_0000, 8'hA5, 1'b1};
    tbl[19] = '{A_GIN,         1'b0, 32'h0,         8'h3C, 32'h0000_003C, 8'hA5, 1'b1};

    for (int i = 0; i < 2**AW; i++) m_ram[i] = 32'd0;
    do_reset();

    // Preload RAM so no later read sees an unwritten word.
    for (int i = 0; i < 2**AW; i++) step(32'(i) << 2, 1'b1, 32'd0);

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      gpioIn = tbl[i].gin;
      drive(tbl[i].addr, tbl[i].we, tbl[i].wd);
      check($sformatf("tbl%0d_rdata", i), dmRData, tbl[i].exp_rd);
      check($sformatf("tbl%0d_gpioOut", i), 32'(gpioOut), 32'(tbl[i].exp_gout));
      check($sformatf("tbl%0d_busErr", i), 32'(busErr), 32'(tbl[i].exp_berr));
      edge_step();
    end

    // Reset clears the sticky error
    do_reset();
    drive(A_GOUT, 1'b0, 32'd0);
    check("busErr_after_rst", 32'(busErr), 32'd0);
    edge_step();

    // Reset arriving with a write in flight drops the write
    step(A_GOUT, 1'b1, 32'h0000_005A);
    @(posedge clk); #1;
    dmAddr = A_GOUT; dmWe = 1'b1; dmWData = 32'h0000_00FF; rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_gpioOut", 32'(gpioOut), 32'd0);
    @(posedge clk); #1;
    check("rst_write_dropped", 32'(gpioOut), 32'd0);
    rst = 1'b0; dmWe = 1'b0;
    model_reset();

`ifdef SM_DMEM_TIMER_EN
    // Timer: match 16 clocks after programming with PRESC=4, CMP=3
    step(A_CMP, 1'b1, 32'd3);
    step(A_STAT, 1'b1, 32'd2);
    found = -1;
    for (int i = 0; i < 40; i++) begin
      drive(A_STAT, 1'b0, 32'd0);
      if (dmRData[0]) begin
        found = since_rst;
        break;
      end
      edge_step();
    end
    check("match_cycle", 32'(found), 32'd16);
    check("match_stat", dmRData, 32'd3);
    check("match_irq", 32'(irq), 32'd1);
    edge_step();
    drive(A_CNT, 1'b0, 32'd0);
    check("cnt_wrapped", dmRData, 32'd0);
    edge_step();
    drive(A_STAT, 1'b1, 32'd1);
    check("irq_before_w1c", 32'(irq), 32'd1);
    edge_step();
    drive(A_CNT, 1'b1, 32'd7);
    check("irq_after_w1c", 32'(irq), 32'd0);
    check("tick_cycle_for_cnt_wr", 32'(since_rst % PRESC), 32'(PRESC - 1));
    edge_step();
    drive(A_CNT, 1'b0, 32'd0);
    check("cnt_write_wins", dmRData, 32'd7);
    edge_step();
    step(A_CMP, 1'b1, 32'd7);
    drive(A_STAT, 1'b0, 32'd0);
    check("stat_clear", dmRData, 32'd0);
    edge_step();
    drive(A_STAT, 1'b1, 32'd3);
    check("tick_cycle_for_w1c", 32'(since_rst % PRESC), 32'(PRESC - 1));
    edge_step();
    drive(A_STAT, 1'b0, 32'd0);
    check("set_beats_w1c", dmRData, 32'd3);
    check("set_beats_w1c_irq", 32'(irq), 32'd1);
    edge_step();
`else
    // Timer absent: registers read 0 and irq never rises
    step(A_CMP, 1'b1, 32'd0);
    step(A_STAT, 1'b1, 32'd2);
    drive(A_CMP, 1'b0, 32'd0);
    check("off_cmp", dmRData, 32'd0);
    edge_step();
    drive(A_STAT, 1'b0, 32'd0);
    check("off_stat", dmRData, 32'd0);
    check("off_busErr", 32'(busErr), 32'd0);
    edge_step();
    for (int i = 0; i < 100; i++) begin
      drive(A_CNT, 1'b0, 32'd0);
      check("off_irq", 32'(irq), 32'd0);
      edge_step();
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, wd;
      logic [15:0] hi;
      int          r;
      r  = $urandom_range(0, 99);
      wd = $urandom;
      if (r < 45) begin
        a = {16'h0000, 16'($urandom)};
      end else if (r < 90) begin
        a = {16'h8000, 16'($urandom)};
        if (a[4:2] == 3'd2 || a[4:2] == 3'd3) wd = 32'($urandom_range(0, 6));
      end else begin
        hi = 16'($urandom);
        if (hi == 16'h0000 || hi == 16'h8000) hi = 16'h1234;
        a = {hi, 16'($urandom)};
      end
      gpioIn = GPIO_W'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      step(a, 1'($urandom_range(0, 1)), wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sm_dmem_responder.md
# sm_dmem_responder

Data-memory target for the pipelined core's M-stage data port: it answers `dmAddr`/`dmWe`/`dmWData` with `dmRData`. It decodes each access into on-chip RAM, a small memory-mapped I/O register bank (GPIO plus an optional compare timer), or an unmapped region. It sits between the CPU top and the board pins and provides the core's only load/store-visible state outside the register file.

## Interface
- `AW`, 6: RAM word-address width; RAM holds 2^AW 32-bit words.
- `GPIO_W`, 8: GPIO input and output width, 1..32.
- `PRESC`, 4: timer prescaler; the timer ticks once every PRESC clocks; PRESC ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `dmAddr`  in  32  byte address; bits [1:0] ignored.
- `dmWe`  in  1  write enable for the current cycle.
- `dmWData`  in  32  write data.
- `dmRData`  out  32  read data; combinational from `dmAddr`.
- `gpioIn`  in  GPIO_W  asynchronous board inputs.
- `gpioOut`  out  GPIO_W  GPIO output register.
- `irq`  out  1  timer interrupt: `match & ie`.
- `busErr`  out  1  sticky flag: a write went to an unmapped address.

## Operation
- Address decode:
  - `dmAddr[31:16]==16'h0000` selects RAM. Word index is `dmAddr[AW+1:2]`. Higher bits in [15:AW+2] alias, so RAM wraps modulo 2^AW words.
  - `dmAddr[31:16]==16'h8000` selects MMIO. Register index is `dmAddr[4:2]`; bits [15:5] are ignored, so MMIO aliases.
  - Every other address is unmapped. Reads return 0. Writes are dropped and set `busErr`.
- MMIO registers:
  - 0 GPIO_OUT: RW, low GPIO_W bits; upper bits read 0.
  - 1 GPIO_IN: RO; returns `gpioIn` after a 2-flop synchronizer, zero-extended.
  - 2 TIMER_CNT: RW.
  - 3 TIMER_CMP: RW.
  - 4 TIMER_STAT: bit0 `match` (write 1 to clear), bit1 `ie` (RW); other bits read 0.
  - 5 ID: RO constant 32'h534D_0001.
  - 6–7: read 0; writes ignored with no `busErr`.
- Writes to RO registers are ignored with no `busErr`.
- Prescaler:
  - Counter runs 0..PRESC-1.
  - `tick` is asserted in the cycle the counter equals PRESC-1; the counter then wraps to 0.
- Timer update on `tick`:
  - If `cnt==cmp`: `cnt<=0` and `match<=1`.
  - Otherwise `cnt<=cnt+1`, modulo 2^32.
- Simultaneous events:
  - A CPU write to TIMER_CNT in the same cycle as `tick` wins; no increment or match occurs that cycle.
  - A match set and a W1C clear of `match` in the same cycle: set wins.
  - Writing TIMER_CMP has no effect on the current cycle's compare; the new value is used from the next cycle.
- RAM contents are not reset; a read before the first write returns X in simulation.

## Timing
- Reads are zero-latency combinational. `dmRData` reflects state as of the last clock edge. A read and write to the same location in the same cycle returns the old value.
- Writes take effect on the rising edge where `dmWe=1`; the new value is readable the next cycle. This matches the core's M→W capture.
- GPIO_IN latency: a pin change is visible to reads 2 edges later.
- `gpioOut` and `busErr` are registered. `irq` is combinational from registered `match` and `ie`.
- Reset values (asynchronous, immediate):
  - `gpioOut=0`, `cnt=0`, `cmp=32'hFFFF_FFFF`, `match=0`, `ie=0`.
  - Prescaler = 0, synchronizer flops = 0, `busErr=0`, so `irq=0`.
- Reset asserted mid-operation aborts any in-flight write. Registers return to reset values regardless of `dmWe`.
- After reset deassertion, the first `tick` occurs PRESC edges later.

## Configuration
- `SM_DMEM_TIMER_EN` defined: prescaler, TIMER_CNT, TIMER_CMP and TIMER_STAT are built as described.
- `SM_DMEM_TIMER_EN` undefined:
  - Timer logic is not instantiated.
  - Registers 2–4 read 0; writes to them are ignored with no `busErr`.
  - `irq` is tied to 0.
  - RAM, GPIO, ID and `busErr` are unchanged.

## Test plan
- RAM write/read and wrap: with AW=6, write 32'hCAFE_0001 at byte address 0x0004, then read 0x0004 → CAFE_0001. Read 0x0104 (aliases word 1) → CAFE_0001. A same-cycle read of 0x0004 during a write of 0x1234 returns the old value.
- GPIO: write 32'hFFFF_FFA5 to 0x8000_0000 → `gpioOut=8'hA5`, and a read returns 0x0000_00A5. Drive `gpioIn=8'h3C`: a read of 0x8000_0004 returns 0x3C on the second cycle after the change, not the first.
- Timer match/irq with PRESC=4:
  - Reset, then write 3 to CMP and 0x2 to STAT.
  - `match` sets 16 clocks after the write; `cnt` goes 0,1,2,3,0; `irq=1`.
  - Write 1 to STAT → `irq=0` the next cycle.
- Collisions: write 7 to CNT on a `tick` cycle → CNT reads 7 next cycle. A W1C of STAT on the cycle `match` sets → `match` stays 1.
- Unmapped and RO accesses:
  - Write to 0x4000_0000 → `busErr=1` (sticky), and a read there returns 0.
  - Write to ID → ignored, ID still reads 0x534D_0001, and `busErr` is unaffected.
  - Assert `rst` → `busErr=0`.
- Macro off: rebuild without `SM_DMEM_TIMER_EN`, write CMP=0 and STAT=0x2 → reads return 0, `irq` stays 0 for 100 cycles, and GPIO/RAM checks still pass.
